// File: rtl/fp_div_pkg.sv
// Shared definitions for the fp_library dividers: FSM encoding, magnitude helper, STEPS check.
// Latency: n/a (types, functions and a macro only).
// Backpressure: n/a.
`define FP_DIV_CHECK_STEPS(aw, steps) if (((aw) % (steps)) != 0) begin : g_steps_check $error("divider: STEPS must divide AW exactly"); end

package fp_div_pkg;

  // Widest operand the magnitude helper handles; callers sign-extend into it.
  localparam int MAG_W = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Magnitude of a sign-extended operand; passes the value through when unsigned.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] value,
                                               input logic             is_signed);
    return (is_signed && value[MAG_W-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/divi_step.sv
// Combinational restoring-division slice: STEPS chained shift/compare/subtract steps, MSB first.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the outputs.
module divi_step #(
  parameter int BW    = 24,
  parameter int STEPS = 1
) (
  input  logic [BW:0]      rem_i,
  input  logic [STEPS-1:0] dbits_i,
  input  logic [BW-1:0]    div_i,
  output logic [BW:0]      rem_o,
  output logic [STEPS-1:0] q_o
);

  localparam int RW = BW + 1;

  logic [RW-1:0] r;
  logic [RW:0]   t;

  // Each step shifts in the next dividend bit and subtracts the divisor when it fits.
  always_comb begin
    r   = rem_i;
    t   = '0;
    q_o = '0;
    for (int i = STEPS - 1; i >= 0; i--) begin
      t = {r, dbits_i[i]};
      if (t >= {2'b00, div_i}) begin
        t      = t - {2'b00, div_i};
        q_o[i] = 1'b1;
      end
      r = RW'(t);
    end
    rem_o = r;
  end

endmodule

// File: rtl/divi_iter_gen.sv
// Iterative restoring divider (unsigned/signed), one operation in flight, STEPS quotient bits per cycle.
// Latency: AW/STEPS+2 cycles from accept to vldout; 2 cycles for divide-by-zero and signed overflow.
// Backpressure: rdyin only in IDLE; result held in DONE until rdyout; en=0 freezes everything.
module divi_iter_gen
  import fp_div_pkg::*;
#(
  parameter int AW        = 48,
  parameter int BW        = 24,
  parameter int STEPS     = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vldin,
  output logic          rdyin,
  input  logic [AW-1:0] ain,
  input  logic [BW-1:0] bin,
  input  logic          signed_mode,
  output logic          vldout,
  input  logic          rdyout,
  output logic [AW-1:0] out,
  output logic [BW-1:0] remainder,
  output logic          div0,
  output logic          ovf,
  output logic          busy
);

  localparam int NITER = AW / STEPS;
  localparam int CW    = (NITER > 1) ? $clog2(NITER) : 1;

  `FP_DIV_CHECK_STEPS(AW, STEPS)

  if (BW > AW) begin : g_bw_check
    $error("divi_iter_gen: BW must not exceed AW");
  end

  div_state_e    state_q;
  logic [AW-1:0] a_q;       // dividend, then |a|, then shifts into the quotient
  logic [BW-1:0] b_q;       // divisor, then |b|
  logic [BW:0]   r_q;       // partial remainder
  logic [CW-1:0] cnt_q;
  logic          sgn_q;
  logic          qneg_q;
  logic          rneg_q;
  logic          vldout_q;
  logic          div0_q;
  logic          ovf_q;
  logic [AW-1:0] out_q;
  logic [BW-1:0] rem_q;

  logic          sgn_d;
  logic          sa_d;
  logic          sb_d;
  logic          div0_d;
  logic          ovf_d;
  logic [AW-1:0] a_mag_d;
  logic [BW-1:0] b_mag_d;
  logic [AW-1:0] a_shift_d;
  logic [AW-1:0] q_fix_d;
  logic [BW-1:0] r_fix_d;
  logic [BW:0]   r_step;
  logic [STEPS-1:0] q_step;

  assign sgn_d = signed_mode & (SIGNED_EN != 0);

  divi_step #(
    .BW   (BW),
    .STEPS(STEPS)
  ) u_step (
    .rem_i  (r_q),
    .dbits_i(a_q[AW-1 -: STEPS]),
    .div_i  (b_q),
    .rem_o  (r_step),
    .q_o    (q_step)
  );

  // Operand signs, magnitudes, exception flags and sign fix-up of the raw result.
  always_comb begin
    sa_d      = sgn_q & a_q[AW-1];
    sb_d      = sgn_q & b_q[BW-1];
    a_mag_d   = AW'(abs_mag({{(MAG_W-AW){sa_d}}, a_q}, sgn_q));
    b_mag_d   = BW'(abs_mag({{(MAG_W-BW){sb_d}}, b_q}, sgn_q));
    div0_d    = (b_q == '0);
    ovf_d     = sgn_q & (a_q == {1'b1, {(AW-1){1'b0}}}) & (&b_q);
    a_shift_d = (a_q << STEPS) | AW'(q_step);
    q_fix_d   = qneg_q ? -a_q : a_q;
    r_fix_d   = rneg_q ? -r_q[BW-1:0] : r_q[BW-1:0];
  end

  // Control FSM with datapath and registered result outputs; en gates every update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      vldout_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      rem_q    <= '0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (vldin) begin
            a_q     <= ain;
            b_q     <= bin;
            sgn_q   <= sgn_d;
            state_q <= PREP;
          end
        end
        PREP: begin
          a_q     <= a_mag_d;
          b_q     <= b_mag_d;
          qneg_q  <= sa_d ^ sb_d;
          rneg_q  <= sa_d;
          div0_q  <= div0_d;
          ovf_q   <= ovf_d;
          r_q     <= '0;
          cnt_q   <= CW'(NITER - 1);
          state_q <= (div0_d || ovf_d) ? FIX : ITER;
        end
        ITER: begin
          a_q <= a_shift_d;
          r_q <= r_step;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          if (div0_q) begin
            out_q <= '0;
            rem_q <= '0;
          end else if (ovf_q) begin
            out_q <= {1'b1, {(AW-1){1'b0}}};
            rem_q <= '0;
          end else begin
            out_q <= q_fix_d;
            rem_q <= r_fix_d;
          end
          vldout_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (rdyout) begin
            vldout_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdyin     = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign vldout    = vldout_q;
  assign out       = out_q;
  assign remainder = rem_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule
